// File: rtl/twn_serial_pkg.sv
// Shared definitions for the TWN serial link (to_serial / from_serial).
// Holds the state encoding and the helpers that derive chunk and counter widths.
package twn_serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of one chunk: a word is cut into cycs equal slices.
    function automatic int chunk_width(input int bw, input int cycs);
        return bw / cycs;
    endfunction

    // Chunk counter width, never narrower than 2 bits.
    function automatic int cnt_width(input int cycs);
        return ($clog2(cycs) < 2) ? 2 : $clog2(cycs);
    endfunction

endpackage

// File: rtl/to_serial_lane.sv
// One lane of the parallel-to-serial converter: a BW-bit register that is
// loaded with a word and then shifted right by one chunk per cycle, so the
// low CW bits always hold the chunk currently on the wire. Zeros fill from the top.
module to_serial_lane #(
    parameter int BW = 16,
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic          shift,
    input  logic [BW-1:0] word,
    output logic [CW-1:0] chunk
);

    logic [BW-1:0] sreg;

    // Load takes priority so a back-to-back reload on the last chunk wins over the shift.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= word;
        end else if (shift) begin
            sreg <= sreg >> CW;
        end
    end

    assign chunk = sreg[CW-1:0];

endmodule

// File: rtl/to_serial.sv
// Parallel-to-serial converter: each of VEC_LEN words of BW bits is emitted as
// CYCS consecutive chunks of BW/CYCS bits, least-significant chunk first.
// Optional build macro TO_SERIAL_PIPE_EN: accept the next vector on the last
// chunk of the current one, giving back-to-back words with no valid bubble.
//
// state | meaning
// IDLE  | no word in flight, ready for a new vector
// SHIFT | emitting chunk cnt of the loaded word
module to_serial
    import twn_serial_pkg::*;
#(
    parameter int BW      = 16,
    parameter int CYCS    = 4,
    parameter int VEC_LEN = 27
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  vld_in,
    output logic                                  rdy_out,
    input  logic [VEC_LEN-1:0][BW-1:0]            in,
    output logic                                  vld_out,
    output logic                                  last_out,
    output logic [VEC_LEN-1:0][chunk_width(BW, CYCS)-1:0] out
);

    localparam int CW    = chunk_width(BW, CYCS);
    localparam int CNT_W = cnt_width(CYCS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCS - 1);

    if ((BW % CYCS) != 0 || CYCS < 2) begin : g_bad_params
        $error("to_serial: BW must be divisible by CYCS and CYCS must be >= 2");
    end

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic                     at_last;
    logic                     accept;
    logic [VEC_LEN-1:0][CW-1:0] lane_chunk;

    assign at_last = (cnt == CNT_LAST);

    // Ready depends only on state and counter so upstream never sees a loop through vld_in.
`ifdef TO_SERIAL_PIPE_EN
    assign rdy_out = (state == IDLE) || ((state == SHIFT) && at_last);
`else
    assign rdy_out = (state == IDLE);
`endif

    assign accept   = vld_in && rdy_out;
    assign vld_out  = (state == SHIFT);
    assign last_out = vld_out && at_last;

    // Sequencer: load on accept, walk cnt through the chunks, return to IDLE unless reloaded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (at_last) begin
                        cnt <= '0;
                        if (!accept) begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
        to_serial_lane #(
            .BW (BW),
            .CW (CW)
        ) u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (accept),
            .shift   (vld_out),
            .word    (in[i]),
            .chunk   (lane_chunk[i])
        );

        // Output forced to zero whenever no chunk is valid.
        assign out[i] = vld_out ? lane_chunk[i] : '0;
    end

endmodule
